// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MDR data path.
// Latches a request in IDLE, waits WAIT_STATES cycles, performs one RAM
// access and then holds mem_ack until the requester drops mem_req.
// Optional build macro: MEM_PARITY_EN (adds a stored even-parity bit,
// par_inject input and parity_err output).
//
// state  | meaning
// IDLE   | waiting for mem_req; request fields latched on acceptance
// WAIT   | counting down programmed wait states
// ACCESS | single-cycle RAM write or read
// ACK    | mem_ack asserted until mem_req is released
module mem_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_data_out,
`ifdef MEM_PARITY_EN
    input  logic                  par_inject,
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  mem_ack,
    output logic                  mem_busy
);

`ifdef MEM_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  latch, ack_nxt, busy_nxt, ram_wr, ram_rd;
    logic [RAM_W-1:0]      ram [2**ADDR_WIDTH];
    logic [RAM_W-1:0]      wr_word, rd_word;

`ifdef MEM_PARITY_EN
    logic inj_q;
    assign wr_word = {(^data_q) ^ inj_q, data_q};
`else
    assign wr_word = data_q;
`endif
    assign rd_word = ram[addr_q];

    // Next-state, counter and registered-output next values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        ack_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    latch    = 1'b1;
                    busy_nxt = 1'b1;
                    if (WS_CNT == 4'd0) begin
                        state_nxt = ST_ACCESS;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS_CNT;
                    end
                end
            end
            ST_WAIT: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                // Leaving when the count is at 1 gives exactly WAIT_STATES cycles here
                if (cnt <= 4'd1) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy_nxt  = 1'b1;
                ram_wr    = we_q;
                ram_rd    = ~we_q;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (mem_req) begin
                    ack_nxt  = 1'b1;
                    busy_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, wait counter and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            mem_ack  <= 1'b0;
            mem_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_ack  <= ack_nxt;
            mem_busy <= busy_nxt;
        end
    end

    // Request field capture on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
`ifdef MEM_PARITY_EN
            inj_q  <= 1'b0;
`endif
        end else if (latch) begin
            we_q   <= mem_we;
            addr_q <= bus_addr;
            data_q <= bus_data_out;
`ifdef MEM_PARITY_EN
            inj_q  <= par_inject;
`endif
        end
    end

    // RAM write; reset suppresses a write on the same edge, contents are kept
    always_ff @(posedge clk) begin
        if (rst_n && ram_wr) begin
            ram[addr_q] <= wr_word;
        end
    end

    // Read data (and parity check) captured during a read ACCESS only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_data_in <= '0;
`ifdef MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (ram_rd) begin
            bus_data_in <= rd_word[DATA_WIDTH-1:0];
`ifdef MEM_PARITY_EN
            parity_err  <= rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]);
`endif
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one instance with WAIT_STATES=2 and
// one with WAIT_STATES=0, driven through a shared transfer task.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n, rst0_n;
    logic       req2, we2, req0, we0;
    logic [4:0] addr2, addr0;
    logic [7:0] dout2, dout0, din2, din0;
    logic       ack2, busy2, ack0, busy0;
    logic       inj2, inj0;
`ifdef MEM_PARITY_EN
    logic       perr2, perr0;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(req2), .mem_we(we2),
        .bus_addr(addr2), .bus_data_out(dout2),
`ifdef MEM_PARITY_EN
        .par_inject(inj2), .parity_err(perr2),
`endif
        .bus_data_in(din2), .mem_ack(ack2), .mem_busy(busy2)
    );

    mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .mem_req(req0), .mem_we(we0),
        .bus_addr(addr0), .bus_data_out(dout0),
`ifdef MEM_PARITY_EN
        .par_inject(inj0), .parity_err(perr0),
`endif
        .bus_data_in(din0), .mem_ack(ack0), .mem_busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int w);
        return (w == 0) ? ack0 : ack2;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy0 : busy2;
    endfunction

    function automatic logic [7:0] get_din(input int w);
        return (w == 0) ? din0 : din2;
    endfunction

    task automatic drive(input int w, input logic r, input logic we, input logic [4:0] a,
                         input logic [7:0] d, input logic inj);
        if (w == 0) begin
            req0 = r; we0 = we; addr0 = a; dout0 = d; inj0 = inj;
        end else begin
            req2 = r; we2 = we; addr2 = a; dout2 = d; inj2 = inj;
        end
    endtask

    // Full four-phase transfer: checks latency, busy, read data, hold and release.
    // chg scrambles addr/data/we after acceptance; hold keeps req high after ack.
    task automatic xfer(input int w, input logic we, input logic [4:0] a, input logic [7:0] d,
                        input int lat, input int hold, input logic chg,
                        input logic [7:0] rd_exp, input logic inj);
        int cyc;
        drive(w, 1'b1, we, a, d, inj);
        tick();
        chk("busy_at_accept", 32'(get_busy(w)), 32'd1);
        if (chg) drive(w, 1'b1, ~we, ~a, ~d, ~inj);
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (get_ack(w)) break;
            if (get_busy(w) !== 1'b1) begin
                chk("busy_in_flight", 32'(get_busy(w)), 32'd1);
            end
        end
        chk("ack_latency", 32'(cyc), 32'(lat));
        chk("busy_with_ack", 32'(get_busy(w)), 32'd1);
        if (!we) chk("read_data", 32'(get_din(w)), 32'(rd_exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ack_held", 32'(get_ack(w)), 32'd1);
            chk("busy_held", 32'(get_busy(w)), 32'd1);
        end
        drive(w, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        chk("ack_release", 32'(get_ack(w)), 32'd0);
        chk("busy_release", 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rst0_n = 1'b0;
        drive(2, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        drive(0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst_ack", 32'(ack2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_din", 32'(din2), 32'd0);
        rst_n = 1'b1; rst0_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy2), 32'd0);

        // Write then read with default wait states
        xfer(2, 1'b1, 5'h03, 8'hA5, 4, 0, 1'b0, 8'h00, 1'b0);
        chk("write_keeps_din", 32'(din2), 32'd0);
        xfer(2, 1'b0, 5'h03, 8'h00, 4, 0, 1'b0, 8'hA5, 1'b0);

        // Requester holds req five cycles after ack
        xfer(2, 1'b0, 5'h03, 8'h00, 4, 5, 1'b0, 8'hA5, 1'b0);
        tick();
        chk("no_second_xfer_busy", 32'(busy2), 32'd0);
        chk("no_second_xfer_ack", 32'(ack2), 32'd0);

        // Reset during the WAIT phase of a write abandons it
        xfer(2, 1'b1, 5'h07, 8'h11, 4, 0, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b1, 1'b1, 5'h07, 8'hFF, 1'b0);
        tick();
        chk("wait_busy", 32'(busy2), 32'd1);
        rst_n = 1'b0;
        drive(2, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
        tick();
        chk("midrst_ack", 32'(ack2), 32'd0);
        chk("midrst_busy", 32'(busy2), 32'd0);
        chk("midrst_din", 32'(din2), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("after_rst_idle", 32'(busy2), 32'd0);
        xfer(2, 1'b0, 5'h07, 8'h00, 4, 0, 1'b0, 8'h11, 1'b0);

        // Zero and MSB-only data, last value held between transfers
        xfer(2, 1'b1, 5'h10, 8'h00, 4, 0, 1'b0, 8'h00, 1'b0);
        xfer(2, 1'b0, 5'h10, 8'h00, 4, 0, 1'b0, 8'h00, 1'b0);
        xfer(2, 1'b1, 5'h11, 8'h80, 4, 0, 1'b0, 8'h00, 1'b0);
        chk("din_hold_over_write", 32'(din2), 32'd0);
        xfer(2, 1'b0, 5'h11, 8'h00, 4, 0, 1'b0, 8'h80, 1'b0);
        tick();
        tick();
        chk("din_hold_idle", 32'(din2), 32'h80);

        // Zero wait states; inputs scrambled after acceptance are ignored
        xfer(0, 1'b1, 5'h00, 8'h55, 2, 0, 1'b0, 8'h00, 1'b0);
        xfer(0, 1'b1, 5'h1F, 8'h3C, 2, 0, 1'b0, 8'h00, 1'b0);
        xfer(0, 1'b0, 5'h1F, 8'h00, 2, 0, 1'b1, 8'h3C, 1'b0);
        xfer(0, 1'b0, 5'h00, 8'h00, 2, 0, 1'b0, 8'h55, 1'b0);

`ifdef MEM_PARITY_EN
        xfer(2, 1'b1, 5'h05, 8'h07, 4, 0, 1'b0, 8'h00, 1'b1);
        xfer(2, 1'b0, 5'h05, 8'h00, 4, 0, 1'b0, 8'h07, 1'b0);
        chk("parity_err_injected", 32'(perr2), 32'd1);
        xfer(2, 1'b1, 5'h05, 8'h07, 4, 0, 1'b0, 8'h00, 1'b0);
        chk("parity_err_held_over_write", 32'(perr2), 32'd1);
        xfer(2, 1'b0, 5'h05, 8'h00, 4, 0, 1'b0, 8'h07, 1'b0);
        chk("parity_err_clean", 32'(perr2), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
